zbt_sample_port: RTL

- Data-side partner of the address calculator; sits between the AC97 sample path and the ZBT SRAM.
- Record mode: packs three consecutive 12-bit samples into one 36-bit ZBT word and writes it at the address presented by the address calculator.
- Playback mode: reads the word at that address and unpacks it into three samples, one per AC97 ready strobe.
- One ZBT access per three samples, matching the calculator's one-address-per-three-samples increment.

---
 rtl/zbt_sample_port.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/zbt_sample_port.sv
// Purpose : packs three AC97 samples per 36-bit ZBT word (record) or unpacks one read word into three samples (playback).
// Latency : write 1 clk after the third record strobe; sample_valid READ_LAT+2 clk after every accepted playback strobe.
// Backpr.  : none; a strobe landing in WRITE or RD_WAIT is dropped and raises the sticky overrun flag.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   ready, record_mode, song_done       AC97 slot strobe and mode/gating from the address calculator
//   mem_address, sample_in              word address and record sample
//   zbt_addr, zbt_we, zbt_wdata,        ZBT SRAM side (READ_LAT-cycle read pipeline)
//   zbt_rdata
//   sample_out, sample_valid, overrun   playback sample, its strobe, sticky error flag
module zbt_sample_port #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 19,
    parameter int READ_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ready,
    input  logic                    record_mode,
    input  logic                    song_done,
    input  logic [ADDR_W-1:0]       mem_address,
    input  logic [SAMPLE_W-1:0]     sample_in,
    output logic [ADDR_W-1:0]       zbt_addr,
    output logic                    zbt_we,
    output logic [3*SAMPLE_W-1:0]   zbt_wdata,
    input  logic [3*SAMPLE_W-1:0]   zbt_rdata,
    output logic [SAMPLE_W-1:0]     sample_out,
    output logic                    sample_valid,
    output logic                    overrun
);

    localparam int WORD_W = 3 * SAMPLE_W;
    // Stages ahead of the sample_valid register; together they give READ_LAT+2.
    localparam int PIPE_D = READ_LAT + 1;
    localparam int CNT_W  = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        WRITE   = 3'd2,
        RD_WAIT = 3'd3,
        PLAY    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          phase;
    logic                word_mode;     // record_mode captured at the phase-0 strobe
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   pack;
    logic [WORD_W-1:0]   hold;
    logic [CNT_W-1:0]    rd_cnt;
    logic [PIPE_D-1:0]   vld_pipe;
    logic [1:0]          slot_pipe [PIPE_D];

    logic                accept;
    logic                abort;
    logic                busy;
    logic                take;
    logic                play_take;
    logic                rd_done;
    logic [WORD_W-1:0]   src_word;

    // Slot 0 is the most significant field of the word.
    function automatic logic [SAMPLE_W-1:0] field(input logic [WORD_W-1:0] w, input logic [1:0] slot);
        logic [SAMPLE_W-1:0] f;
        f = '0;
        case (slot)
            2'd0:    f = w[3*SAMPLE_W-1:2*SAMPLE_W];
            2'd1:    f = w[2*SAMPLE_W-1:SAMPLE_W];
            2'd2:    f = w[SAMPLE_W-1:0];
            default: f = '0;
        endcase
        return f;
    endfunction

    // A partial word dies when the mode flips or the song ends before slot 2.
    // A word that already reached WRITE has phase 0 and is not affected.
    assign accept    = ready & ~song_done;
    assign abort     = (phase != 2'd0) & (song_done | (record_mode != word_mode));
    assign busy      = (state == WRITE) | (state == RD_WAIT);
    assign take      = accept & ~abort & ~busy;
    assign play_take = take & ~record_mode;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (take) state_nxt = record_mode ? FILL : RD_WAIT;
                end
                FILL: begin
                    if (take && phase == 2'd2) state_nxt = WRITE;
                end
                WRITE: begin
                    state_nxt = IDLE;
                end
                RD_WAIT: begin
                    if (rd_done) state_nxt = PLAY;
                end
                PLAY: begin
                    if (take && phase == 2'd2) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // zbt_we decodes straight from the state register so reset kills it at once.
    always_comb begin
        zbt_we  = 1'b0;
        rd_done = 1'b0;
        case (state)
            WRITE:   zbt_we  = 1'b1;
            RD_WAIT: rd_done = (rd_cnt == CNT_W'(READ_LAT));
            default: ;
        endcase
    end

    // The capture cycle lines up with the slot-0 entry leaving the delay line,
    // so slot 0 is taken straight off the read bus instead of the hold register.
    assign src_word = rd_done ? zbt_rdata : hold;

    // ---------------- phase, word bookkeeping, write path ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= 2'd0;
            word_mode <= 1'b0;
            addr_q    <= '0;
            pack      <= '0;
            zbt_addr  <= '0;
            zbt_wdata <= '0;
            overrun   <= 1'b0;
        end else begin
            if (accept && !abort && busy) begin
                overrun <= 1'b1;
            end

            if (abort || song_done) begin
                phase <= 2'd0;
            end else if (take) begin
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end

            if (abort) begin
                pack <= '0;
            end else if (take) begin
                if (phase == 2'd0) begin
                    word_mode <= record_mode;
                    if (record_mode) begin
                        addr_q <= mem_address;
                        pack   <= {sample_in, {(2*SAMPLE_W){1'b0}}};
                    end else begin
                        // Read is issued the cycle after the strobe.
                        zbt_addr <= mem_address;
                    end
                end else if (state == FILL) begin
                    if (phase == 2'd1) begin
                        pack[2*SAMPLE_W-1:SAMPLE_W] <= sample_in;
                    end else begin
                        pack[SAMPLE_W-1:0] <= sample_in;
                        zbt_addr           <= addr_q;
                        zbt_wdata          <= {pack[WORD_W-1:SAMPLE_W], sample_in};
                    end
                end
            end
        end
    end

    // ---------------- read path and sample delay line ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt       <= '0;
            hold         <= '0;
            vld_pipe     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < PIPE_D; i++) begin
                slot_pipe[i] <= 2'd0;
            end
        end else begin
            if (state == RD_WAIT) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end else begin
                rd_cnt <= '0;
            end

            if (rd_done) begin
                hold <= zbt_rdata;
            end

            for (int i = PIPE_D - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                slot_pipe[i] <= slot_pipe[i-1];
            end
            vld_pipe[0]  <= play_take;
            slot_pipe[0] <= phase;

            // Samples of a discarded word never reach the output.
            if (abort) begin
                vld_pipe <= '0;
            end

            sample_valid <= vld_pipe[PIPE_D-1] & ~abort;
            if (vld_pipe[PIPE_D-1] && !abort) begin
                sample_out <= field(src_word, slot_pipe[PIPE_D-1]);
            end
        end
    end

endmodule
